// File: rtl/mem_access_sequencer_pkg.sv
// Shared constants, state encoding and request-screening helpers for the
// load/store memory access sequencer.
package mem_access_sequencer_pkg;

    localparam int MAS_DATA_WIDTH = 32;

    // memLength encodings shared with the decoder and the store path
    localparam logic [1:0] MEMLEN_BYTE = 2'd0;
    localparam logic [1:0] MEMLEN_HALF = 2'd1;
    localparam logic [1:0] MEMLEN_WORD = 2'd3;

    typedef enum logic [1:0] {
        MAS_IDLE   = 2'd0,
        MAS_ACCESS = 2'd1,
        MAS_DONE   = 2'd2
    } mas_state_e;

    // Index of the final byte of an access (nbytes - 1).
    function automatic logic [1:0] mas_last_idx(input logic [1:0] len);
        logic [1:0] r;
        case (len)
            MEMLEN_BYTE: r = 2'd0;
            MEMLEN_HALF: r = 2'd1;
            MEMLEN_WORD: r = 2'd3;
            default:     r = 2'd0;
        endcase
        return r;
    endfunction

    // A request is rejected for an illegal length, an ambiguous or empty
    // direction, or a misaligned half/word address.
    function automatic logic mas_reject(input logic       ld,
                                        input logic       st,
                                        input logic [1:0] len,
                                        input logic [1:0] addr_lo);
        logic bad_len;
        logic bad_dir;
        logic bad_align;
        bad_len   = (len == 2'd2);
        bad_dir   = (ld & st) | ~(ld | st);
        bad_align = ((len == MEMLEN_HALF) & addr_lo[0]) |
                    ((len == MEMLEN_WORD) & (addr_lo != 2'b00));
        return bad_len | bad_dir | bad_align;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_load_extender.sv
// Combinational sign/zero extension of an assembled little-endian load word.
// Also used by the writeback mux, so it stays free of state.
module load_extender
    import mem_access_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = MAS_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] raw,
    input  logic [1:0]            mem_length,
    input  logic                  load_unsigned,
    output logic [DATA_WIDTH-1:0] ext
);

    // Select the fill bit from the top of the loaded field unless unsigned.
    always_comb begin
        ext = raw;
        case (mem_length)
            MEMLEN_BYTE: ext = {{(DATA_WIDTH-8){~load_unsigned & raw[7]}}, raw[7:0]};
            MEMLEN_HALF: ext = {{(DATA_WIDTH-16){~load_unsigned & raw[15]}}, raw[15:0]};
            MEMLEN_WORD: ext = raw;
            default:     ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store sequencer: walks a byte-wide little-endian memory
// one byte per req/ack handshake, stalls the core with busy and returns an
// extended load result alongside a one-cycle done pulse.
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = MAS_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  load,
    input  logic                  store,
    input  logic                  loadUnsigned,
    input  logic [1:0]            memLength,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] storeData,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] loadData,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack
);

    mas_state_e            state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic                  store_q, store_d;
    logic                  uns_q, uns_d;
    logic [1:0]            len_q, len_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  busy_q, busy_d;
    logic                  req_ready_q, req_ready_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;

    logic [DATA_WIDTH-1:0] asm_fill_s;
    logic [DATA_WIDTH-1:0] ext_s;

    // Assembly word with the byte arriving this cycle dropped into its lane.
    always_comb begin
        asm_fill_s = asm_q;
        asm_fill_s[{idx_q, 3'b000} +: 8] = mem_rdata;
    end

    load_extender #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
        .raw           (asm_fill_s),
        .mem_length    (len_q),
        .load_unsigned (uns_q),
        .ext           (ext_s)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        store_d     = store_q;
        uns_d       = uns_q;
        len_d       = len_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        load_data_d = load_data_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        busy_d      = busy_q;
        req_ready_d = req_ready_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            MAS_IDLE: begin
                if (req_valid) begin
                    store_d     = store;
                    uns_d       = loadUnsigned;
                    len_d       = memLength;
                    base_d      = address;
                    wdata_d     = storeData;
                    idx_d       = 2'd0;
                    asm_d       = '0;
                    busy_d      = 1'b1;
                    req_ready_d = 1'b0;
                    if (mas_reject(load, store, memLength, address[1:0])) begin
                        state_d = MAS_DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d     = MAS_ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = store;
                        mem_addr_d  = address;
                        mem_wdata_d = storeData[7:0];
                    end
                end else begin
                    busy_d      = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            MAS_ACCESS: begin
                if (mem_ack) begin
                    asm_d = asm_fill_s;
                    if (idx_q == mas_last_idx(len_q)) begin
                        state_d     = MAS_DONE;
                        done_d      = 1'b1;
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = '0;
                        mem_wdata_d = 8'd0;
                        if (store_q) begin
                            load_data_d = load_data_q;
                        end else begin
                            load_data_d = ext_s;
                        end
                    end else begin
                        idx_d       = idx_q + 2'd1;
                        // modulo 2^ADDR_WIDTH by construction of the adder width
                        mem_addr_d  = base_q + {{(ADDR_WIDTH-2){1'b0}}, idx_d};
                        mem_wdata_d = wdata_q[{idx_d, 3'b000} +: 8];
                    end
                end else begin
                    // wait state: hold every mem_* output exactly as issued
                    idx_d = idx_q;
                end
            end
            MAS_DONE: begin
                state_d     = MAS_IDLE;
                busy_d      = 1'b0;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = MAS_IDLE;
                busy_d      = 1'b0;
                req_ready_d = 1'b1;
                mem_req_d   = 1'b0;
            end
        endcase
    end

    // State, request latch and registered outputs; reset aborts any access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= MAS_IDLE;
            idx_q       <= 2'd0;
            store_q     <= 1'b0;
            uns_q       <= 1'b0;
            len_q       <= 2'd0;
            base_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            load_data_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            store_q     <= store_d;
            uns_q       <= uns_d;
            len_q       <= len_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign loadData  = load_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed scoreboard bench for mem_access_sequencer with a byte RAM model
// that can insert wait states on every byte.
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic        loadUnsigned = 1'b0;
    logic [1:0]  memLength = 2'd0;
    logic [31:0] address = 32'd0;
    logic [31:0] storeData = 32'd0;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] loadData;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack = 1'b0;

    mem_access_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .load         (load),
        .store        (store),
        .loadUnsigned (loadUnsigned),
        .memLength    (memLength),
        .address      (address),
        .storeData    (storeData),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .loadData     (loadData),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic we; logic [7:0] data; } xfer_t;
    typedef struct { logic err; logic [31:0] ld; } res_t;

    xfer_t       xq[$];
    res_t        sq[$];
    logic [7:0]  ram [0:1023];
    logic [31:0] exp_ld = 32'd0;
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          stall_cfg = 0;
    int          stall_cnt = 0;
    bit          stalled = 1'b0;
    logic [40:0] held = 41'd0;

    assign mem_rdata = ram[mem_addr[9:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit model_bad(input logic ld, input logic st, input logic [1:0] len, input logic [31:0] a);
        bit b;
        b = 1'b0;
        if (ld == st) b = 1'b1;
        if (len == 2'd2) b = 1'b1;
        if (len == 2'd1 && a[0]) b = 1'b1;
        if (len == 2'd3 && a[1:0] != 2'b00) b = 1'b1;
        return b;
    endfunction

    function automatic int model_n(input logic [1:0] len);
        return (len == 2'd0) ? 1 : ((len == 2'd1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] len, input logic un);
        logic [31:0] w;
        logic [31:0] r;
        w = {ram[a[9:0] + 10'd3], ram[a[9:0] + 10'd2], ram[a[9:0] + 10'd1], ram[a[9:0]]};
        if (len == 2'd0) r = un ? {24'h000000, w[7:0]} : {{24{w[7]}}, w[7:0]};
        else if (len == 2'd1) r = un ? {16'h0000, w[15:0]} : {{16{w[15]}}, w[15:0]};
        else r = w;
        return r;
    endfunction

    // RAM responder, byte-transfer scoreboard and done-result scoreboard.
    always @(negedge clk) begin
        xfer_t x;
        res_t  r;
        if (reset_n) begin
            if (mem_req) begin
                if (xq.size() == 0) begin
                    chk("spurious_mem_req", {63'd0, mem_req}, 64'd0);
                    mem_ack = 1'b1;
                end else begin
                    if (stalled) chk("mem_stable", {23'd0, held}, {23'd0, mem_addr, mem_we, mem_wdata});
                    if (stall_cnt >= stall_cfg) begin
                        mem_ack = 1'b1;
                        stall_cnt = 0;
                        stalled = 1'b0;
                        x = xq.pop_front();
                        chk("mem_addr", {32'd0, mem_addr}, {32'd0, x.addr});
                        chk("mem_we", {63'd0, mem_we}, {63'd0, x.we});
                        if (x.we) begin
                            chk("mem_wdata", {56'd0, mem_wdata}, {56'd0, x.data});
                            ram[mem_addr[9:0]] = mem_wdata;
                        end
                    end else begin
                        mem_ack = 1'b0;
                        stall_cnt++;
                        stalled = 1'b1;
                        held = {mem_addr, mem_we, mem_wdata};
                    end
                end
            end else begin
                mem_ack = 1'b0;
                stall_cnt = 0;
                stalled = 1'b0;
            end
            if (done) begin
                if (sq.size() == 0) begin
                    chk("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    r = sq.pop_front();
                    chk("done_error", {63'd0, error}, {63'd0, r.err});
                    chk("done_loadData", {32'd0, loadData}, {32'd0, r.ld});
                    chk("done_busy", {63'd0, busy}, 64'd1);
                end
            end else begin
                chk("error_outside_done", {63'd0, error}, 64'd0);
            end
        end else begin
            mem_ack = 1'b0;
            stall_cnt = 0;
            stalled = 1'b0;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_error"}, {63'd0, error}, 64'd0);
        chk({tag, "_loadData"}, {32'd0, loadData}, 64'd0);
        chk({tag, "_mem_req"}, {63'd0, mem_req}, 64'd0);
        chk({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
        chk({tag, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
        chk({tag, "_mem_wdata"}, {56'd0, mem_wdata}, 64'd0);
    endtask

    // Called at a negedge: queue expectations, drive and hold until accepted.
    task automatic send(input logic ld, input logic st, input logic un, input logic [1:0] len,
                        input logic [31:0] a, input logic [31:0] sd, output int t_acc);
        res_t  r;
        xfer_t x;
        bit    bad;
        bit    ok;
        bad = model_bad(ld, st, len, a);
        if (!bad && ld) exp_ld = model_load(a, len, un);
        r.err = bad;
        r.ld  = exp_ld;
        sq.push_back(r);
        if (!bad) begin
            for (int i = 0; i < model_n(len); i++) begin
                x.addr = a + i;
                x.we   = st;
                x.data = sd[8*i +: 8];
                xq.push_back(x);
            end
        end
        req_valid = 1'b1; load = ld; store = st; loadUnsigned = un;
        memLength = len; address = a; storeData = sd;
        ok = 1'b0;
        t_acc = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (req_ready) begin
                t_acc = cyc;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) chk("accept_timeout", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0; load = 1'b0; store = 1'b0;
        if (ok) begin
            chk("busy_after_accept", {63'd0, busy}, 64'd1);
            chk("ready_after_accept", {63'd0, req_ready}, 64'd0);
        end
    endtask

    task automatic wait_done(output int t);
        bit ok;
        ok = 1'b0;
        t = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            if (done) begin
                t = cyc;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) chk("done_timeout", {63'd0, done}, 64'd1);
    endtask

    initial begin
        int ta;
        int td;
        int ta2;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h78; ram[10'h101] = 8'h56; ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
        ram[10'h007] = 8'h80;
        ram[10'h201] = 8'h11; ram[10'h202] = 8'h22; ram[10'h203] = 8'h33;
        ram[10'h040] = 8'hFF; ram[10'h041] = 8'h7F;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // LW aligned, no wait states
        send(1'b1, 1'b0, 1'b0, 2'd3, 32'h100, 32'd0, ta);
        wait_done(td);
        chk("lw_latency", 64'(td - ta), 64'd5);

        // LB / LBU of 0x80
        send(1'b1, 1'b0, 1'b0, 2'd0, 32'h7, 32'd0, ta);
        wait_done(td);
        chk("lb_latency", 64'(td - ta), 64'd2);
        send(1'b1, 1'b0, 1'b1, 2'd0, 32'h7, 32'd0, ta);
        wait_done(td);
        chk("lbu_latency", 64'(td - ta), 64'd2);

        // SH with two wait states per byte
        stall_cfg = 2;
        send(1'b0, 1'b1, 1'b0, 2'd1, 32'h22, 32'hDEADBEEF, ta);
        wait_done(td);
        stall_cfg = 0;
        chk("sh_ram22", {56'd0, ram[10'h022]}, 64'hEF);
        chk("sh_ram23", {56'd0, ram[10'h023]}, 64'hBE);
        send(1'b1, 1'b0, 1'b1, 2'd1, 32'h22, 32'd0, ta);
        wait_done(td);
        send(1'b1, 1'b0, 1'b0, 2'd1, 32'h22, 32'd0, ta);
        wait_done(td);

        // rejected requests: no memory traffic, done one cycle after accept
        send(1'b1, 1'b0, 1'b0, 2'd3, 32'h102, 32'd0, ta);
        wait_done(td);
        chk("rej_lw_latency", 64'(td - ta), 64'd1);
        send(1'b1, 1'b0, 1'b0, 2'd1, 32'h1, 32'd0, ta);
        wait_done(td);
        chk("rej_lh_latency", 64'(td - ta), 64'd1);
        send(1'b1, 1'b0, 1'b0, 2'd2, 32'h10, 32'd0, ta);
        wait_done(td);
        chk("rej_len2_latency", 64'(td - ta), 64'd1);
        send(1'b1, 1'b1, 1'b0, 2'd0, 32'h10, 32'd0, ta);
        wait_done(td);
        chk("rej_ldst_latency", 64'(td - ta), 64'd1);
        send(1'b0, 1'b0, 1'b0, 2'd0, 32'h10, 32'd0, ta);
        wait_done(td);
        chk("rej_none_latency", 64'(td - ta), 64'd1);

        // reset in the middle of an SW after its first byte
        send(1'b0, 1'b1, 1'b0, 2'd3, 32'h200, 32'hA1B2C3D4, ta);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        xq.delete();
        sq.delete();
        exp_ld = 32'd0;
        chk("midreset_ram200", {56'd0, ram[10'h200]}, 64'hD4);
        chk("midreset_ram201", {56'd0, ram[10'h201]}, 64'h11);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(1'b1, 1'b0, 1'b0, 2'd3, 32'h200, 32'd0, ta);
        wait_done(td);
        chk("post_reset_latency", 64'(td - ta), 64'd5);

        // back-to-back LH then SB
        send(1'b1, 1'b0, 1'b0, 2'd1, 32'h40, 32'd0, ta);
        wait_done(td);
        send(1'b0, 1'b1, 1'b0, 2'd0, 32'h41, 32'h0000005A, ta2);
        chk("b2b_accept_gap", 64'(ta2 - td), 64'd1);
        wait_done(td);
        chk("sb_ram41", {56'd0, ram[10'h041]}, 64'h5A);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(sq.size() + xq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
